// File: rtl/play_timer_multi.sv
// play_timer_multi: per-track mm:ss elapsed-time counters with switch, pause and read-back.
// Define PLAY_TIMER_SEEK_EN to add the load/seek port.
module play_timer_multi #(
  parameter int NUM_TRACKS      = 4,
  parameter int MAX_MINS        = 59,
  parameter bit CLEAR_ON_SWITCH = 1,
  parameter int SEL_W           = 2
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             tick_1hz,
  input  logic             pause,
  input  logic [SEL_W-1:0] track_sel,
  input  logic [SEL_W-1:0] rd_track,
`ifdef PLAY_TIMER_SEEK_EN
  input  logic             load,
  input  logic [5:0]       load_mins,
  input  logic [5:0]       load_secs,
`endif
  output logic [SEL_W-1:0] cur_track,
  output logic [5:0]       mins,
  output logic [5:0]       secs,
  output logic [5:0]       rd_mins,
  output logic [5:0]       rd_secs,
  output logic             wrap
);
  localparam int DEPTH = 1 << SEL_W;
  localparam logic [SEL_W:0] NT = (SEL_W+1)'(NUM_TRACKS);
  localparam logic [5:0] MM = 6'(MAX_MINS);
  // storage spans the full select range so every index is in bounds; slots >= NUM_TRACKS stay 0
  logic [5:0] m_r [DEPTH];
  logic [5:0] s_r [DEPTH];
  logic ld;
  logic [5:0] lm, ls;
`ifdef PLAY_TIMER_SEEK_EN
  assign ld = load;
  assign lm = load_mins > MM ? MM : load_mins;
  assign ls = load_secs > 6'd59 ? 6'd59 : load_secs;
`else
  assign ld = 1'b0;
  assign lm = '0;
  assign ls = '0;
`endif
  logic sw, cnt, at_end, rd_ok;
  logic [SEL_W-1:0] tgt;
  logic [5:0] cm, cs, nm, ns;
  always_comb begin
    sw     = ({1'b0, track_sel} < NT) && (track_sel != cur_track);
    tgt    = sw ? track_sel : cur_track;
    cm     = m_r[tgt];
    cs     = s_r[tgt];
    cnt    = tick_1hz && !pause && !sw && !ld;
    at_end = cs == 6'd59 && cm == MM;
    nm     = ld ? lm : !cnt ? cm : at_end ? '0 : cs == 6'd59 ? cm + 6'd1 : cm;
    ns     = ld ? ls : !cnt ? cs : cs == 6'd59 ? '0 : cs + 6'd1;
    rd_ok  = {1'b0, rd_track} < NT;
  end
  always_ff @(posedge clk) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_r[i] <= '0;
        s_r[i] <= '0;
      end
      cur_track <= '0;
      rd_mins   <= '0;
      rd_secs   <= '0;
      wrap      <= 1'b0;
    end else begin
      if (sw && CLEAR_ON_SWITCH) begin
        m_r[cur_track] <= '0;
        s_r[cur_track] <= '0;
      end
      m_r[tgt]  <= nm;
      s_r[tgt]  <= ns;
      cur_track <= tgt;
      rd_mins   <= rd_ok ? m_r[rd_track] : '0;
      rd_secs   <= rd_ok ? s_r[rd_track] : '0;
      wrap      <= cnt && at_end;
    end
  end
  assign mins = m_r[cur_track];
  assign secs = s_r[cur_track];
endmodule

// File: tb/tb_play_timer_multi.sv
// tb_play_timer_multi: two configurations driven in lockstep, scored against a total-seconds model.
module tb_play_timer_multi;
  localparam int SW = 3;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, pause = 1'b0;
  logic [SW-1:0] sel = '0, rd = '0;
  logic ld = 1'b0;
  logic [5:0] lmi = '0, lsi = '0;
  logic [SW-1:0] cur0, cur1;
  logic [5:0] m0, s0, rm0, rs0, m1, s1, rm1, rs1;
  logic w0, w1;

  always #5 clk = ~clk;

  play_timer_multi #(.NUM_TRACKS(4), .MAX_MINS(59), .CLEAR_ON_SWITCH(1), .SEL_W(SW)) u0 (
    .clk(clk), .RESET(rst), .tick_1hz(tick), .pause(pause), .track_sel(sel), .rd_track(rd),
`ifdef PLAY_TIMER_SEEK_EN
    .load(ld), .load_mins(lmi), .load_secs(lsi),
`endif
    .cur_track(cur0), .mins(m0), .secs(s0), .rd_mins(rm0), .rd_secs(rs0), .wrap(w0));

  play_timer_multi #(.NUM_TRACKS(3), .MAX_MINS(1), .CLEAR_ON_SWITCH(0), .SEL_W(SW)) u1 (
    .clk(clk), .RESET(rst), .tick_1hz(tick), .pause(pause), .track_sel(sel), .rd_track(rd),
`ifdef PLAY_TIMER_SEEK_EN
    .load(ld), .load_mins(lmi), .load_secs(lsi),
`endif
    .cur_track(cur1), .mins(m1), .secs(s1), .rd_mins(rm1), .rd_secs(rs1), .wrap(w1));

  typedef struct packed {
    logic [2:0] cur;
    logic [5:0] m, s, rm, rs;
    logic w;
  } exp_t;
  exp_t q0[$], q1[$];
  int checks = 0, errors = 0;
  int nt[2] = '{4, 3};
  int mx[2] = '{59, 1};
  bit clr[2] = '{1'b1, 1'b0};
  int t[2][8];
  int cur[2], rdv[2];
  bit wr[2];

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // elapsed time per track is kept as total seconds modulo the track period
  function automatic void model_edge();
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        for (int k = 0; k < 8; k++) t[c][k] = 0;
        cur[c] = 0; rdv[c] = 0; wr[c] = 0;
      end else begin
        int period = (mx[c] + 1) * 60;
        bit swc;
        rdv[c] = (int'(rd) < nt[c]) ? t[c][rd] : 0;
        swc = int'(sel) < nt[c] && int'(sel) != cur[c];
        if (swc) begin
          if (clr[c]) t[c][cur[c]] = 0;
          cur[c] = int'(sel);
        end
        wr[c] = 0;
        if (ld)
          t[c][cur[c]] = (int'(lmi) > mx[c] ? mx[c] : int'(lmi)) * 60 + (int'(lsi) > 59 ? 59 : int'(lsi));
        else if (tick && !pause && !swc) begin
          t[c][cur[c]]++;
          if (t[c][cur[c]] == period) begin
            t[c][cur[c]] = 0;
            wr[c] = 1;
          end
        end
      end
    end
  endfunction

  function automatic exp_t mk(int c);
    exp_t e;
    e.cur = 3'(cur[c]);
    e.m = 6'(t[c][cur[c]] / 60);
    e.s = 6'(t[c][cur[c]] % 60);
    e.rm = 6'(rdv[c] / 60);
    e.rs = 6'(rdv[c] % 60);
    e.w = wr[c];
    return e;
  endfunction

  task automatic cyc(bit tk, bit ps, int sl, int r);
    tick = tk; pause = ps; sel = SW'(sl); rd = SW'(r);
    @(posedge clk);
    model_edge();
    q0.push_back(mk(0));
    q1.push_back(mk(1));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("u0.cur", cur0, e.cur); chk("u0.mins", m0, e.m); chk("u0.secs", s0, e.s);
      chk("u0.rd_mins", rm0, e.rm); chk("u0.rd_secs", rs0, e.rs); chk("u0.wrap", w0, e.w);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("u1.cur", cur1, e.cur); chk("u1.mins", m1, e.m); chk("u1.secs", s1, e.s);
      chk("u1.rd_mins", rm1, e.rm); chk("u1.rd_secs", rs1, e.rs); chk("u1.wrap", w1, e.w);
    end
  end

  initial begin
    int s_cur, tk;
    @(negedge clk);
    do_reset();
    chk("reset_cur", cur0, 0); chk("reset_secs", s0, 0);
    repeat (75) cyc(1, 0, 0, 0);
    chk("t75_mins", m0, 1); chk("t75_secs", s0, 15);
    do_reset();
    repeat (42) cyc(1, 0, 0, 0);
    repeat (10) cyc(1, 1, 0, 0);
    chk("pause_secs", s0, 42);
    cyc(1, 0, 0, 0);
    chk("resume_secs", s0, 43);
    do_reset();
    repeat (10) cyc(1, 0, 0, 0);
    cyc(1, 0, 2, 0);
    chk("switch_tick_drop", s0, 0);
    repeat (5) cyc(1, 0, 2, 0);
    cyc(0, 0, 0, 2);
    cyc(0, 0, 0, 2);
    chk("keep_resume_secs", s1, 10); chk("clear_resume_secs", s0, 0);
    chk("keep_rd_secs", rs1, 5); chk("clear_rd_secs", rs0, 0);
    cyc(1, 0, 5, 0);
    chk("sel5_cur", cur0, 0);
    cyc(0, 0, 3, 0);
    chk("sel3_u0_cur", cur0, 3); chk("sel3_u1_cur", cur1, 0);
    do_reset();
    repeat (119) cyc(1, 0, 0, 0);
    chk("pre_wrap_mins", m1, 1); chk("pre_wrap_secs", s1, 59);
    cyc(1, 0, 0, 0);
    chk("wrap_pulse", w1, 1); chk("wrap_mins", m1, 0); chk("wrap_secs", s1, 0);
    cyc(0, 0, 0, 0);
    chk("wrap_drop", w1, 0);
    do_reset();
    repeat (3600) cyc(1, 0, 0, 0);
    chk("u0_wrap_pulse", w0, 1); chk("u0_wrap_mins", m0, 0);
    cyc(1, 0, 1, 0);
    repeat (7) cyc(1, 0, 1, 0);
    rst = 1'b1;
    cyc(1, 0, 2, 0);
    rst = 1'b0;
    chk("midreset_cur", cur0, 0); chk("midreset_secs", s0, 0);
    cyc(1, 0, 0, 0);
    chk("after_reset_secs", s0, 1);
`ifdef PLAY_TIMER_SEEK_EN
    ld = 1'b1; lmi = 6'd2; lsi = 6'd70;
    cyc(1, 0, 0, 0);
    ld = 1'b0;
    chk("seek_mins", m0, 2); chk("seek_secs", s0, 59); chk("seek_wrap", w0, 0);
    chk("seek_clamp_mins", m1, 1);
`endif
    s_cur = 0;
    repeat (3000) begin
      rst = ($urandom_range(0, 199) == 0);
      tk = $urandom_range(0, 1);
      if ($urandom_range(0, 19) == 0) s_cur = $urandom_range(0, 7);
`ifdef PLAY_TIMER_SEEK_EN
      ld = ($urandom_range(0, 31) == 0);
      lmi = 6'($urandom_range(0, 63));
      lsi = 6'($urandom_range(0, 63));
`endif
      cyc(tk[0], $urandom_range(0, 4) == 0, s_cur, $urandom_range(0, 7));
    end
    rst = 1'b0; ld = 1'b0;
    repeat (2) @(negedge clk);
    chk("queue_drain", q0.size() + q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
